// File: rtl/cpu_pkg.sv
// Shared definitions for the game-hard board CPU: opcodes, ALU and branch
// selectors, the instruction word layout, UART register addresses and the
// ALU / branch-compare helper functions.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ALUI = 4'h0,
        OP_ALUR = 4'h1,
        OP_LW   = 4'h4,
        OP_SW   = 4'h5,
        OP_BR   = 4'h6,
        OP_JALR = 4'h7,
        OP_HALT = 4'hA
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_op_e;

    typedef enum logic [3:0] {
        BR_EQ = 4'd0,
        BR_NE = 4'd1,
        BR_LT = 4'd2,
        BR_GE = 4'd3
    } br_op_e;

    typedef struct packed {
        logic [11:0] imm12;
        logic [3:0]  rs2;
        logic [3:0]  rs1;
        logic [3:0]  rd;
        logic [3:0]  opt;
        logic [3:0]  opcode;
    } instr_t;

    localparam logic [31:0] UART_TX_ADDR   = 32'hFFFF_FFFF;
    localparam logic [31:0] UART_STAT_ADDR = 32'hFFFF_FFFE;

    // Unused opt codes fall back to add.
    function automatic logic [31:0] alu(input logic [3:0] opt,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (opt)
            ALU_SUB: alu = a - b;
            ALU_AND: alu = a & b;
            ALU_OR:  alu = a | b;
            ALU_XOR: alu = a ^ b;
            ALU_SLL: alu = a << b[4:0];
            ALU_SRL: alu = a >> b[4:0];
            ALU_SRA: alu = sa >>> b[4:0];
            default: alu = a + b;
        endcase
    endfunction

    function automatic logic br_taken(input logic [3:0] opt,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (opt)
            BR_EQ:   br_taken = (a == b);
            BR_NE:   br_taken = (a != b);
            BR_LT:   br_taken = (sa < sb);
            BR_GE:   br_taken = (sa >= sb);
            default: br_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu.sv
// Single-cycle 32-bit CPU, 16 registers, word-addressed, 10-bit pc.
// Ports: clk, reset; instr/pc to the ROM; mem_addr/mem_wdata/mem_we/mem_re/
//        mem_rdata to the data bus; stall holds the current instruction.
module cpu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic [9:0]  pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        stall
);
    instr_t      ins;
    logic [31:0] imm, rs1_val, rs2_val, rd_val;
    logic        rd_we_raw, rd_we, halted;
    logic [9:0]  pc_next, pc_inc;

    assign ins    = instr_t'(instr);
    assign imm    = {{20{ins.imm12[11]}}, ins.imm12};
    assign pc_inc = pc + 10'd1;

    gr_file gr_file (
        .clk (clk),
        .reset (reset),
        .we  (rd_we),
        .wa  (ins.rd),
        .wd  (rd_val),
        .ra1 (ins.rs1),
        .ra2 (ins.rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val)
    );

    // Bus controls are kept out of the decode block: stall is derived from
    // mem_we outside this module and feeds back into the retire logic.
    assign mem_addr  = rs1_val + imm;
    assign mem_wdata = rs2_val;
    assign mem_we    = !halted && (ins.opcode == OP_SW);
    assign mem_re    = !halted && (ins.opcode == OP_LW);

    always_comb begin
        rd_we_raw = 1'b0;
        rd_val    = '0;
        pc_next   = pc_inc;
        case (ins.opcode)
            OP_ALUI: begin
                rd_we_raw = 1'b1;
                rd_val    = alu(ins.opt, rs1_val, imm);
            end
            OP_ALUR: begin
                rd_we_raw = 1'b1;
                rd_val    = alu(ins.opt, rs1_val, rs2_val);
            end
            OP_LW: begin
                rd_we_raw = 1'b1;
                rd_val    = mem_rdata;
            end
            OP_BR: begin
                if (br_taken(ins.opt, rs1_val, rs2_val))
                    pc_next = pc + imm[9:0];
            end
            OP_JALR: begin
                rd_we_raw = 1'b1;
                rd_val    = {22'b0, pc_inc};
                pc_next   = mem_addr[9:0];
            end
            OP_HALT: pc_next = pc;
            default: ;
        endcase
    end

    assign rd_we = rd_we_raw && !halted && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            halted <= 1'b0;
        end else if (!halted && !stall) begin
            pc <= pc_next;
            if (ins.opcode == OP_HALT)
                halted <= 1'b1;
        end
    end
endmodule

// File: rtl/gr_file.sv
// General register file: 16 x 32-bit, x[0] hard-wired to zero.
// Ports: clk, reset (sync, clears all), we/wa/wd write port,
//        ra1/rd1 and ra2/rd2 combinational read ports.
module gr_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  wa,
    input  logic [31:0] wd,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [15:0][31:0] x;

    always_ff @(posedge clk) begin
        if (reset)
            x <= '0;
        else if (we && wa != 4'd0)
            x[wa] <= wd;
    end

    assign rd1 = x[ra1];
    assign rd2 = x[ra2];
endmodule

// File: rtl/ram.sv
// Data RAM: 1024 x 32-bit, combinational read, write on the rising edge.
// Contents are not affected by reset.
// Ports: clk, we, addr (word address), wdata, rdata.
module ram (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] mem [0:1023];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/rom.sv
// Instruction ROM: 1024 x 32-bit, combinational read. Starts all-zero; the
// contents are written hierarchically by the bench.
// Ports: addr (word address), data (instruction word).
module rom #(
  parameter string FILENAME = ""
) (
  input  logic [9:0]  addr,
  output logic [31:0] data
);
  logic [31:0] mem [0:1023];

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = '0;
  end

  assign data = mem[addr];
endmodule

// File: rtl/uart.sv
// 8N1 UART, WAIT clocks per bit, separate TX and RX state machines.
// Ports: clk, reset; rx/tx serial lines (idle 1); tx_start/tx_data launch a
//        frame, tx_busy while sending; rx_valid/rx_byte hold the last good
//        byte, rx_clr clears rx_valid.
module uart #(
    parameter int WAIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    input  logic       rx_clr,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);
    localparam int CW = $clog2(WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT - 1);
    localparam logic [CW-1:0] HALF = CW'(WAIT / 2 - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    tx_state_e       tx_state, tx_state_n;
    logic [9:0]      tx_shift;
    logic [3:0]      tx_bit;
    logic [CW-1:0]   tx_cnt;

    rx_state_e       rx_state, rx_state_n;
    logic            rx_s1, rx_s2;
    logic [7:0]      rx_shift;
    logic [2:0]      rx_bit;
    logic [CW-1:0]   rx_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else begin
            tx_state <= tx_state_n;
            rx_state <= rx_state_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_start) tx_state_n = TX_SEND;
            TX_SEND: if (tx_cnt == LAST && tx_bit == 4'd9) tx_state_n = TX_IDLE;
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Shift register holds {stop, data, start}; bit 0 is on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift <= '1;
            tx_bit   <= '0;
            tx_cnt   <= '0;
        end else if (tx_state == TX_IDLE) begin
            if (tx_start)
                tx_shift <= {1'b1, tx_data, 1'b0};
            tx_bit <= '0;
            tx_cnt <= '0;
        end else if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= tx_bit + 4'd1;
            tx_shift <= {1'b1, tx_shift[9:1]};
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign tx_busy = (tx_state == TX_SEND);
    assign tx      = tx_busy ? tx_shift[0] : 1'b1;

    // START re-checks the line at mid start bit so a glitch is not taken
    // as a frame; later samples land every WAIT cycles from there.
    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s2) rx_state_n = RX_START;
            RX_START: if (rx_cnt == HALF) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == LAST && rx_bit == 3'd7) rx_state_n = RX_STOP;
            RX_STOP:  if (rx_cnt == LAST) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_shift <= '0;
            rx_bit   <= '0;
            rx_cnt   <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            if (rx_state == RX_IDLE || rx_state != rx_state_n || rx_cnt == LAST)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START)
                rx_bit <= '0;
            if (rx_state == RX_DATA && rx_cnt == LAST) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            // A completing frame wins over a same-cycle status read.
            if (rx_state == RX_STOP && rx_cnt == LAST && rx_s2) begin
                rx_valid <= 1'b1;
                rx_byte  <= rx_shift;
            end else if (rx_clr) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/cpu_mother_board.sv
// Top level of the game-hard board: CPU, instruction ROM, data RAM and a
// memory-mapped UART (TX at 0xFFFF_FFFF, status/RX at 0xFFFF_FFFE).
// Ports: clk, reset (sync, active-high), uart_rx in, uart_tx out.
module cpu_mother_board
    import cpu_pkg::*;
#(
    parameter int    WAIT     = 8,
    parameter string FILENAME = ""
) (
    input  logic clk,
    input  logic reset,
    input  logic uart_rx,
    output logic uart_tx
);
    logic [9:0]  pc;
    logic [31:0] instr, mem_addr, mem_wdata, mem_rdata, ram_rdata;
    logic        mem_we, mem_re, stall, is_tx, is_stat;
    logic        tx_busy, rx_valid;
    logic [7:0]  rx_byte;

    assign is_tx   = (mem_addr == UART_TX_ADDR);
    assign is_stat = (mem_addr == UART_STAT_ADDR);
    // A TX store waits in place until the transmitter is free.
    assign stall   = mem_we && is_tx && tx_busy;
    assign mem_rdata = is_stat ? {22'b0, tx_busy, rx_valid, rx_byte} : ram_rdata;

    rom #(.FILENAME(FILENAME)) rom (
        .addr (pc),
        .data (instr)
    );

    cpu cpu (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .pc        (pc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    ram ram (
        .clk   (clk),
        .we    (mem_we && !is_tx && !is_stat),
        .addr  (mem_addr[9:0]),
        .wdata (mem_wdata),
        .rdata (ram_rdata)
    );

    uart #(.WAIT(WAIT)) uart (
        .clk      (clk),
        .reset    (reset),
        .rx       (uart_rx),
        .tx       (uart_tx),
        .tx_start (mem_we && is_tx && !tx_busy),
        .tx_data  (mem_wdata[7:0]),
        .tx_busy  (tx_busy),
        .rx_clr   (mem_re && is_stat),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte)
    );
endmodule

// File: tb/tb_cpu_mother_board.sv
// Directed bench for cpu_mother_board: small programs written into the ROM,
// register/pc/RAM probes, and a scoreboard for UART TX bits and RX bytes.
module tb_cpu_mother_board;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    int vectors = 0;
    int errors = 0;

    logic [31:0] prog[$];
    logic [31:0] tx_exp_q[$];
    logic [31:0] rx_exp_q[$];

    cpu_mother_board #(.WAIT(8), .FILENAME("")) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc(input int imm, input int rs2, input int rs1,
                                        input int rd, input int opt, input int op);
        logic [31:0] v;
        v = {imm[11:0], rs2[3:0], rs1[3:0], rd[3:0], opt[3:0], op[3:0]};
        return v;
    endfunction

    function automatic logic [31:0] xr(input int i);
        return dut.cpu.gr_file.x[i];
    endfunction

    function automatic logic [31:0] pc_now();
        return {22'b0, dut.cpu.pc};
    endfunction

    function automatic logic [31:0] tx_now();
        return {31'b0, uart_tx};
    endfunction

    task automatic check_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_tx(input logic [31:0] obs);
        if (tx_exp_q.size() == 0) begin
            vectors++;
            errors++;
            $error("FAIL tx_sb_empty: observed 0x%08h, expected nothing", obs);
        end else begin
            check_now("tx_bit", obs, tx_exp_q.pop_front());
        end
    endtask

    task automatic sb_rx(input logic [31:0] obs);
        if (rx_exp_q.size() == 0) begin
            vectors++;
            errors++;
            $error("FAIL rx_sb_empty: observed 0x%08h, expected nothing", obs);
        end else begin
            check_now("rx_byte", obs, rx_exp_q.pop_front());
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        tx_exp_q.push_back(32'd0);
        for (int i = 0; i < 8; i++)
            tx_exp_q.push_back({31'b0, b[i]});
        tx_exp_q.push_back(32'd1);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 1024; i++)
            dut.rom.mem[i] = 32'd0;
        for (int i = 0; i < prog.size(); i++)
            dut.rom.mem[i] = prog[i];
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);

        // Store/load through RAM.
        prog = '{enc(3, 0, 0, 2, 0, 0), enc(4, 0, 2, 3, 0, 0), enc(0, 3, 2, 0, 0, 5),
                 enc(0, 0, 2, 4, 0, 4), enc(0, 0, 0, 0, 0, 10)};
        load_prog();
        reset_dut();
        check_now("reset_pc", pc_now(), 32'd0);
        check_now("reset_tx", tx_now(), 32'd1);
        run(5);
        check_now("ls_x2", xr(2), 32'd3);
        check_now("ls_x3", xr(3), 32'd7);
        check_now("ls_x4", xr(4), 32'd7);
        check_now("ls_ram3", dut.ram.mem[3], 32'd7);
        run(3);
        check_now("ls_halt_pc", pc_now(), 32'd4);

        // ALU, x0 write, shift masking, jalr, signed branch.
        prog = '{enc(-1, 0, 0, 1, 0, 0), enc(5, 0, 0, 2, 0, 0), enc(0, 1, 2, 5, 1, 1),
                 enc(1, 0, 1, 6, 7, 0), enc(9, 0, 0, 0, 0, 0), enc(4, 0, 1, 7, 6, 0),
                 enc(0, 2, 1, 8, 4, 1), enc(33, 0, 2, 9, 5, 0), enc(10, 0, 0, 10, 0, 7),
                 enc(1, 0, 0, 11, 0, 0), enc(2, 2, 1, 0, 2, 6), enc(1, 0, 0, 12, 0, 0),
                 enc(0, 0, 0, 0, 0, 10)};
        load_prog();
        reset_dut();
        run(16);
        check_now("alu_sub", xr(5), 32'd6);
        check_now("alu_sra", xr(6), 32'hFFFF_FFFF);
        check_now("alu_x0", xr(0), 32'd0);
        check_now("alu_srl", xr(7), 32'h0FFF_FFFF);
        check_now("alu_xor", xr(8), 32'hFFFF_FFFA);
        check_now("alu_sll33", xr(9), 32'd10);
        check_now("jalr_link", xr(10), 32'd9);
        check_now("jalr_skip", xr(11), 32'd0);
        check_now("blt_skip", xr(12), 32'd0);
        check_now("blt_pc", pc_now(), 32'd12);

        // Countdown loop and halt freeze.
        prog = '{enc(3, 0, 0, 1, 0, 0), enc(-1, 0, 1, 1, 0, 0), enc(-1, 0, 1, 0, 1, 6),
                 enc(0, 0, 0, 0, 0, 10)};
        load_prog();
        reset_dut();
        run(8);
        check_now("loop_x1", xr(1), 32'd0);
        check_now("loop_pc", pc_now(), 32'd3);
        run(20);
        check_now("halt_pc_frozen", pc_now(), 32'd3);
        check_now("halt_x1", xr(1), 32'd0);

        // UART TX: two back-to-back stores, second one stalls.
        prog = '{enc(8'h41, 0, 0, 1, 0, 0), enc(-1, 1, 0, 0, 0, 5), enc(-1, 1, 0, 0, 0, 5),
                 enc(1, 0, 0, 2, 0, 0), enc(0, 0, 0, 0, 0, 10)};
        load_prog();
        push_frame(8'h41);
        push_frame(8'h41);
        reset_dut();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 200 && uart_tx !== 1'b0; i++)
                @(negedge clk);
            check_now("tx_start_seen", tx_now(), 32'd0);
            repeat (4) @(negedge clk);
            for (int b = 0; b < 10; b++) begin
                sb_tx(tx_now());
                if (f == 0 && b == 5) begin
                    check_now("tx_stall_pc", pc_now(), 32'd2);
                    check_now("tx_stall_x2", xr(2), 32'd0);
                end
                if (b < 9)
                    repeat (8) @(negedge clk);
            end
        end
        run(20);
        check_now("tx_after_x2", xr(2), 32'd1);
        check_now("tx_after_pc", pc_now(), 32'd4);
        check_now("tx_idle", tx_now(), 32'd1);

        // UART RX: bad-stop frame dropped, good frame read, second read clear.
        prog = '{enc(-2, 0, 0, 1, 0, 4), enc(12'h100, 0, 1, 2, 2, 0), enc(-2, 0, 2, 0, 0, 6),
                 enc(-2, 0, 0, 3, 0, 4), enc(0, 0, 0, 0, 0, 10)};
        load_prog();
        reset_dut();
        run(5);
        send_rx(8'h33, 1'b0);
        uart_rx = 1'b1;
        run(16);
        rx_exp_q.push_back(32'h0000_015A);
        send_rx(8'h5A, 1'b1);
        for (int i = 0; i < 300 && dut.cpu.pc != 10'd4; i++)
            @(negedge clk);
        check_now("rx_halt_pc", pc_now(), 32'd4);
        sb_rx(xr(1));
        check_now("rx_second_read", xr(3), 32'h0000_005A);

        // Reset in the middle of a program and of a TX start bit.
        prog = '{enc(8'h41, 0, 0, 1, 0, 0), enc(-1, 1, 0, 0, 0, 5), enc(0, 0, 0, 0, 0, 10)};
        load_prog();
        reset_dut();
        run(6);
        check_now("pre_reset_x1", xr(1), 32'h41);
        check_now("pre_reset_tx", tx_now(), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_now("mid_reset_x1", xr(1), 32'd0);
        check_now("mid_reset_pc", pc_now(), 32'd0);
        check_now("mid_reset_tx", tx_now(), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_now("restart_x1", xr(1), 32'h41);
        check_now("restart_pc", pc_now(), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
